// File: rtl/activation_skew_feeder.sv
// Activation skew feeder: unpacks buffer words into lanes, skews row i by i cycles, then drains zeros.
// Lane i reaches ins_o[i] i+1 cycles after acceptance; word_ready_o ignores word_valid_i, stalls become bubbles.
module activation_skew_feeder #(
   parameter int ARRAY_SIZE         = 4,
   parameter int COMPUTE_DATA_WIDTH = 4,
   parameter int BUFFER_WORD_SIZE   = 16,
   parameter int NUM_COMPUTE_LANES  = BUFFER_WORD_SIZE / COMPUTE_DATA_WIDTH,
   parameter int VEC_CNT_WIDTH      = 8
) (
   input  logic                                           clk_i,
   input  logic                                           rst_i,
   input  logic                                           start_i,
   input  logic [VEC_CNT_WIDTH-1:0]                       num_vectors_i,
   input  logic                                           word_valid_i,
   input  logic [BUFFER_WORD_SIZE-1:0]                    word_data_i,
   output logic                                           word_ready_o,
   output logic [ARRAY_SIZE-1:0][COMPUTE_DATA_WIDTH-1:0]  ins_o,
   output logic                                           compute_o,
   output logic                                           busy_o,
   output logic                                           done_o
);
   localparam int DRAIN_LEN = 2 * ARRAY_SIZE - 2;
   localparam int DCW       = $clog2(DRAIN_LEN);

   if (NUM_COMPUTE_LANES != ARRAY_SIZE) begin : g_lane_check
      $fatal(1, "activation_skew_feeder: NUM_COMPUTE_LANES must equal ARRAY_SIZE");
   end
   if (ARRAY_SIZE < 2) begin : g_size_check
      $fatal(1, "activation_skew_feeder: ARRAY_SIZE must be at least 2");
   end

   typedef enum logic [1:0] {S_IDLE, S_FEED, S_DRAIN, S_DONE} state_e;

   state_e                   state_q, state_d;
   logic [VEC_CNT_WIDTH-1:0] acc_q, acc_d;
   logic [VEC_CNT_WIDTH-1:0] nvec_q, nvec_d;
   logic [DCW-1:0]           drain_q, drain_d;
   logic                     active_q, done_q;
   logic                     hs, shift_en;

   assign word_ready_o = (state_q == S_FEED) && (acc_q < nvec_q);
   assign hs           = word_valid_i && word_ready_o;
   assign shift_en     = (state_q == S_FEED) || (state_q == S_DRAIN);

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      nvec_d  = nvec_q;
      drain_d = drain_q;
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               nvec_d  = num_vectors_i;
               acc_d   = '0;
               drain_d = '0;
               state_d = (num_vectors_i == '0) ? S_DONE : S_FEED;
            end
         end
         S_FEED: begin
            if (hs) begin
               acc_d = acc_q + 1'b1;
               // nvec_q is non-zero here, so the subtraction cannot underflow
               if (acc_q == nvec_q - 1'b1) state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (drain_q == DCW'(DRAIN_LEN - 1)) state_d = S_DONE;
            else                                drain_d = drain_q + 1'b1;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q  <= S_IDLE;
         acc_q    <= '0;
         nvec_q   <= '0;
         drain_q  <= '0;
         active_q <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         nvec_q   <= nvec_d;
         drain_q  <= drain_d;
         active_q <= (state_d == S_FEED) || (state_d == S_DRAIN);
         done_q   <= (state_d == S_DONE);
      end
   end

   assign compute_o = active_q;
   assign busy_o    = active_q;
   assign done_o    = done_q;

   // Row r is an (r+1)-deep shift register; stage 0 takes the new lane, stage r drives the array.
   for (genvar r = 0; r < ARRAY_SIZE; r++) begin : g_row
      logic [r:0][COMPUTE_DATA_WIDTH-1:0] pipe_q;
      logic [COMPUTE_DATA_WIDTH-1:0]      lane;

      assign lane = hs ? word_data_i[r*COMPUTE_DATA_WIDTH +: COMPUTE_DATA_WIDTH] : '0;

      if (r == 0) begin : g_first
         always_ff @(posedge clk_i or negedge rst_i) begin
            if (!rst_i)        pipe_q <= '0;
            else if (shift_en) pipe_q <= lane;
         end
      end else begin : g_rest
         always_ff @(posedge clk_i or negedge rst_i) begin
            if (!rst_i)        pipe_q <= '0;
            else if (shift_en) pipe_q <= {pipe_q[r-1:0], lane};
         end
      end

      assign ins_o[r] = pipe_q[r];
   end
endmodule

// File: tb/tb_activation_skew_feeder.sv
// Directed bench for activation_skew_feeder: scheduled inputs per cycle, recorded outputs, hand tables.
module tb_activation_skew_feeder;
   localparam int AS   = 4;
   localparam int CDW  = 4;
   localparam int MAXC = 32;

   logic                    clk = 1'b0;
   logic                    rst;
   logic                    start;
   logic [7:0]              nv;
   logic                    wv;
   logic [15:0]             wd;
   logic                    wr;
   logic [AS-1:0][CDW-1:0]  ins;
   logic                    compute, busy, done;

   int checks = 0;
   int errors = 0;

   logic        s_start [0:MAXC-1];
   logic [7:0]  s_nv    [0:MAXC-1];
   logic        s_valid [0:MAXC-1];
   logic [15:0] s_data  [0:MAXC-1];
   logic [15:0] r_ins   [0:MAXC-1];
   logic        r_cmp   [0:MAXC-1];
   logic        r_busy  [0:MAXC-1];
   logic        r_done  [0:MAXC-1];
   logic        r_rdy   [0:MAXC-1];
   logic [15:0] exp_ins [0:MAXC-1];

   always #5 clk = ~clk;

   activation_skew_feeder dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .start_i       (start),
      .num_vectors_i (nv),
      .word_valid_i  (wv),
      .word_data_i   (wd),
      .word_ready_o  (wr),
      .ins_o         (ins),
      .compute_o     (compute),
      .busy_o        (busy),
      .done_o        (done)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_sched();
      for (int i = 0; i < MAXC; i++) begin
         s_start[i] = 1'b0;  s_nv[i]   = 8'd0;
         s_valid[i] = 1'b0;  s_data[i] = 16'h0;
         exp_ins[i] = 16'h0;
      end
   endtask

   task automatic apply(input int k);
      start = s_start[k];  nv = s_nv[k];
      wv    = s_valid[k];  wd = s_data[k];
   endtask

   // obs k = outputs seen one tick after the k-th edge following the start request
   task automatic run_sched(input int n);
      apply(0);
      for (int k = 1; k <= n; k++) begin
         step();
         r_ins[k] = ins;  r_cmp[k] = compute; r_busy[k] = busy;
         r_done[k] = done; r_rdy[k] = wr;
         apply(k);
      end
   endtask

   task automatic test_reset();
      rst = 1'b0; start = 1'b0; nv = 8'd0; wv = 1'b0; wd = 16'h0;
      #12;
      checks++; if (ins !== 16'h0)   begin errors++; $display("FAIL rst_ins got %h want 0000", ins); end
      checks++; if (compute !== 1'b0) begin errors++; $display("FAIL rst_compute got %b want 0", compute); end
      checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
      checks++; if (done !== 1'b0)    begin errors++; $display("FAIL rst_done got %b want 0", done); end
      checks++; if (wr !== 1'b0)      begin errors++; $display("FAIL rst_ready got %b want 0", wr); end
      step();
      rst = 1'b1;
      step();
   endtask

   task automatic test_single();
      int n_cmp, n_done;
      clear_sched();
      s_start[0] = 1'b1; s_nv[0] = 8'd1;
      for (int i = 0; i < 14; i++) begin s_valid[i] = 1'b1; s_data[i] = 16'h4321; end
      exp_ins[2] = 16'h0001; exp_ins[3] = 16'h0020; exp_ins[4] = 16'h0300; exp_ins[5] = 16'h4000;
      run_sched(12);
      for (int k = 1; k <= 12; k++) begin
         checks++;
         if (r_ins[k] !== exp_ins[k]) begin
            errors++; $display("FAIL single_ins c%0d got %h want %h", k, r_ins[k], exp_ins[k]);
         end
      end
      n_cmp = 0; n_done = 0;
      for (int k = 1; k <= 12; k++) begin n_cmp += int'(r_cmp[k]); n_done += int'(r_done[k]); end
      checks++; if (n_cmp != 7)  begin errors++; $display("FAIL single_compute_cycles got %0d want 7", n_cmp); end
      checks++; if (n_done != 1) begin errors++; $display("FAIL single_done_count got %0d want 1", n_done); end
      checks++; if (r_done[8] !== 1'b1) begin errors++; $display("FAIL single_done_pos got %b want 1", r_done[8]); end
      checks++; if (r_rdy[1] !== 1'b1 || r_rdy[2] !== 1'b0) begin
         errors++; $display("FAIL single_ready got %b%b want 10", r_rdy[1], r_rdy[2]);
      end
   endtask

   task automatic test_back_to_back();
      int n_rdy, n_busy;
      clear_sched();
      s_start[0] = 1'b1; s_nv[0] = 8'd3;
      s_valid[1] = 1'b1; s_data[1] = 16'h1111;
      s_valid[2] = 1'b1; s_data[2] = 16'h2222;
      s_valid[3] = 1'b1; s_data[3] = 16'h3333;
      s_valid[4] = 1'b1; s_data[4] = 16'hEEEE;
      exp_ins[2] = 16'h0001; exp_ins[3] = 16'h0012; exp_ins[4] = 16'h0123;
      exp_ins[5] = 16'h1230; exp_ins[6] = 16'h2300; exp_ins[7] = 16'h3000;
      run_sched(13);
      for (int k = 1; k <= 13; k++) begin
         checks++;
         if (r_ins[k] !== exp_ins[k]) begin
            errors++; $display("FAIL b2b_ins c%0d got %h want %h", k, r_ins[k], exp_ins[k]);
         end
      end
      n_rdy = 0; n_busy = 0;
      for (int k = 1; k <= 13; k++) begin n_rdy += int'(r_rdy[k]); n_busy += int'(r_busy[k]); end
      checks++; if (n_rdy != 3)  begin errors++; $display("FAIL b2b_ready_cycles got %0d want 3", n_rdy); end
      checks++; if (n_busy != 9) begin errors++; $display("FAIL b2b_busy_cycles got %0d want 9", n_busy); end
      checks++; if (r_done[10] !== 1'b1) begin errors++; $display("FAIL b2b_done_pos got %b want 1", r_done[10]); end
   endtask

   task automatic test_backpressure();
      int n_rdy, n_busy, n_cmp;
      clear_sched();
      s_start[0] = 1'b1; s_nv[0] = 8'd2;
      s_valid[1] = 1'b1; s_data[1] = 16'h4321;
      s_valid[2] = 1'b0; s_data[2] = 16'hDEAD;
      s_valid[3] = 1'b0; s_data[3] = 16'hBEEF;
      s_valid[4] = 1'b1; s_data[4] = 16'h8765;
      exp_ins[2] = 16'h0001; exp_ins[3] = 16'h0020; exp_ins[4] = 16'h0300;
      exp_ins[5] = 16'h4005; exp_ins[6] = 16'h0060; exp_ins[7] = 16'h0700; exp_ins[8] = 16'h8000;
      run_sched(14);
      for (int k = 1; k <= 14; k++) begin
         checks++;
         if (r_ins[k] !== exp_ins[k]) begin
            errors++; $display("FAIL bp_ins c%0d got %h want %h", k, r_ins[k], exp_ins[k]);
         end
      end
      n_rdy = 0; n_busy = 0; n_cmp = 0;
      for (int k = 1; k <= 10; k++) n_cmp += int'(r_cmp[k]);
      for (int k = 1; k <= 14; k++) begin n_rdy += int'(r_rdy[k]); n_busy += int'(r_busy[k]); end
      checks++; if (n_cmp != 10)  begin errors++; $display("FAIL bp_compute_held got %0d want 10", n_cmp); end
      checks++; if (n_busy != 10) begin errors++; $display("FAIL bp_pass_len got %0d want 10", n_busy); end
      checks++; if (n_rdy != 4)   begin errors++; $display("FAIL bp_ready_cycles got %0d want 4", n_rdy); end
      checks++; if (r_done[11] !== 1'b1) begin errors++; $display("FAIL bp_done_pos got %b want 1", r_done[11]); end
   endtask

   task automatic test_zero_vectors();
      int n_cmp, n_rdy, n_done;
      clear_sched();
      s_start[0] = 1'b1; s_nv[0] = 8'd0;
      for (int i = 0; i < 6; i++) begin s_valid[i] = 1'b1; s_data[i] = 16'hFFFF; end
      run_sched(5);
      n_cmp = 0; n_rdy = 0; n_done = 0;
      for (int k = 1; k <= 5; k++) begin
         n_cmp += int'(r_cmp[k]); n_rdy += int'(r_rdy[k]); n_done += int'(r_done[k]);
      end
      checks++; if (r_done[1] !== 1'b1) begin errors++; $display("FAIL zero_done_pos got %b want 1", r_done[1]); end
      checks++; if (n_done != 1) begin errors++; $display("FAIL zero_done_count got %0d want 1", n_done); end
      checks++; if (n_cmp != 0)  begin errors++; $display("FAIL zero_compute got %0d want 0", n_cmp); end
      checks++; if (n_rdy != 0)  begin errors++; $display("FAIL zero_ready got %0d want 0", n_rdy); end
   endtask

   task automatic test_start_in_drain();
      int n_rdy, n_busy, n_done;
      clear_sched();
      s_start[0] = 1'b1; s_nv[0] = 8'd1;
      s_valid[1] = 1'b1; s_data[1] = 16'h4321;
      s_start[3] = 1'b1; s_nv[3] = 8'd5;
      for (int i = 3; i < 18; i++) begin s_valid[i] = 1'b1; s_data[i] = 16'h1111; end
      exp_ins[2] = 16'h0001; exp_ins[3] = 16'h0020; exp_ins[4] = 16'h0300; exp_ins[5] = 16'h4000;
      run_sched(16);
      for (int k = 1; k <= 16; k++) begin
         checks++;
         if (r_ins[k] !== exp_ins[k]) begin
            errors++; $display("FAIL drain_start_ins c%0d got %h want %h", k, r_ins[k], exp_ins[k]);
         end
      end
      n_rdy = 0; n_busy = 0; n_done = 0;
      for (int k = 1; k <= 16; k++) begin
         n_rdy += int'(r_rdy[k]); n_busy += int'(r_busy[k]); n_done += int'(r_done[k]);
      end
      checks++; if (n_done != 1) begin errors++; $display("FAIL drain_start_done got %0d want 1", n_done); end
      checks++; if (n_rdy != 1)  begin errors++; $display("FAIL drain_start_ready got %0d want 1", n_rdy); end
      checks++; if (n_busy != 7) begin errors++; $display("FAIL drain_start_busy got %0d want 7", n_busy); end
   endtask

   task automatic test_reset_mid_feed();
      int n_done;
      clear_sched();
      s_start[0] = 1'b1; s_nv[0] = 8'd5;
      s_valid[1] = 1'b1; s_data[1] = 16'h1111;
      s_valid[2] = 1'b1; s_data[2] = 16'h2222;
      run_sched(3);
      checks++; if (r_ins[3] !== 16'h0012) begin errors++; $display("FAIL midrst_pre_ins got %h want 0012", r_ins[3]); end
      rst = 1'b0;
      #1;
      checks++; if (ins !== 16'h0)    begin errors++; $display("FAIL midrst_ins got %h want 0000", ins); end
      checks++; if (compute !== 1'b0) begin errors++; $display("FAIL midrst_compute got %b want 0", compute); end
      checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL midrst_busy got %b want 0", busy); end
      checks++; if (done !== 1'b0)    begin errors++; $display("FAIL midrst_done got %b want 0", done); end
      checks++; if (wr !== 1'b0)      begin errors++; $display("FAIL midrst_ready got %b want 0", wr); end
      step();
      rst = 1'b1;
      step();
      clear_sched();
      s_start[0] = 1'b1; s_nv[0] = 8'd1;
      s_valid[1] = 1'b1; s_data[1] = 16'h4321;
      exp_ins[2] = 16'h0001; exp_ins[3] = 16'h0020; exp_ins[4] = 16'h0300; exp_ins[5] = 16'h4000;
      run_sched(10);
      for (int k = 1; k <= 10; k++) begin
         checks++;
         if (r_ins[k] !== exp_ins[k]) begin
            errors++; $display("FAIL midrst_clean_ins c%0d got %h want %h", k, r_ins[k], exp_ins[k]);
         end
      end
      n_done = 0;
      for (int k = 1; k <= 10; k++) n_done += int'(r_done[k]);
      checks++; if (n_done != 1) begin errors++; $display("FAIL midrst_clean_done got %0d want 1", n_done); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_backpressure();
      test_zero_vectors();
      test_start_in_drain();
      test_reset_mid_feed();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
